// File: rtl/board_scan_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : board_scan_receiver
//  Description : Locks onto the raster-ordered board-scan beat stream, rebuilds
//                the 3x3 board image in a shadow register, and publishes a
//                coherent snapshot (with X/O counts) once per complete frame.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_scan_receiver #(
    parameter int MAX_GAP = 4,
    parameter int GAP_W   = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    input  logic [1:0]  row,
    input  logic [1:0]  col,
    input  logic [1:0]  xoro,
    output logic [17:0] board,
    output logic        frame_valid,
    output logic        changed,
    output logic [3:0]  x_count,
    output logic [3:0]  o_count,
    output logic        locked,
    output logic        seq_err
);

    localparam logic [0:0]       c_hunt    = 1'b0;
    localparam logic [0:0]       c_collect = 1'b1;
    localparam logic [GAP_W-1:0] c_max_gap = GAP_W'(MAX_GAP);
    localparam logic [1:0]       c_cell_x  = 2'b01;
    localparam logic [1:0]       c_cell_o  = 2'b10;

    logic [0:0]       r_state;
    logic [3:0]       r_exp;
    logic [GAP_W-1:0] r_gap;
    logic [17:0]      r_shadow;

    logic [3:0]  w_idx;
    logic        w_good;
    logic        w_first;
    logic [17:0] w_merged;

    // Counts cells of a board image holding the given code.
    function automatic logic [3:0] f_count(input logic [17:0] img, input logic [1:0] code);
        logic [3:0] n;
        n = 4'd0;
        for (int k = 0; k < 9; k++) begin
            if (img[2*k +: 2] == code) begin
                n = n + 4'd1;
            end
        end
        return n;
    endfunction

    // Decode the incoming beat: linear cell index, legality, and start-of-frame.
    always_comb begin
        w_idx   = ({2'b00, row} * 4'd3) + {2'b00, col};
        w_good  = in_valid && (row != 2'd3) && (col != 2'd3) && (xoro != 2'b11);
        w_first = w_good && (w_idx == 4'd0);
    end

    // Shadow image with the current beat's cell overwritten.
    always_comb begin
        w_merged = r_shadow;
        for (int k = 0; k < 9; k++) begin
            if (w_idx == 4'(k)) begin
                w_merged[2*k +: 2] = xoro;
            end
        end
    end

    // Scan-tracking state machine, shadow capture and frame commit.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= c_hunt;
            r_exp       <= 4'd0;
            r_gap       <= '0;
            r_shadow    <= 18'd0;
            board       <= 18'd0;
            frame_valid <= 1'b0;
            changed     <= 1'b0;
            x_count     <= 4'd0;
            o_count     <= 4'd0;
            locked      <= 1'b0;
            seq_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            changed     <= 1'b0;
            seq_err     <= 1'b0;
            case (r_state)
                c_hunt: begin
                    // Only a clean cell-0 beat starts a frame; everything else is noise.
                    if (w_first) begin
                        r_shadow <= {16'd0, xoro};
                        r_exp    <= 4'd1;
                        r_gap    <= '0;
                        r_state  <= c_collect;
                    end
                end
                c_collect: begin
                    if (in_valid) begin
                        if (w_good && (w_idx == r_exp)) begin
                            r_gap    <= '0;
                            r_shadow <= w_merged;
                            if (r_exp == 4'd8) begin
                                // Last cell: publish the whole image atomically.
                                board       <= w_merged;
                                frame_valid <= 1'b1;
                                changed     <= (w_merged != board);
                                x_count     <= f_count(w_merged, c_cell_x);
                                o_count     <= f_count(w_merged, c_cell_o);
                                locked      <= 1'b1;
                                r_exp       <= 4'd0;
                                r_state     <= c_hunt;
                            end else begin
                                r_exp <= r_exp + 4'd1;
                            end
                        end else begin
                            seq_err <= 1'b1;
                            locked  <= 1'b0;
                            r_gap   <= '0;
                            if (w_first) begin
                                // A fresh cell-0 beat resynchronises without a HUNT detour.
                                r_shadow <= {16'd0, xoro};
                                r_exp    <= 4'd1;
                            end else begin
                                r_shadow <= 18'd0;
                                r_exp    <= 4'd0;
                                r_state  <= c_hunt;
                            end
                        end
                    end else if (r_gap == c_max_gap) begin
                        // One idle cycle beyond the tolerated gap aborts the frame.
                        seq_err  <= 1'b1;
                        locked   <= 1'b0;
                        r_gap    <= '0;
                        r_shadow <= 18'd0;
                        r_exp    <= 4'd0;
                        r_state  <= c_hunt;
                    end else begin
                        r_gap <= r_gap + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_hunt;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_board_scan_receiver.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_scan_receiver
//  Description : Self-checking bench for board_scan_receiver; directed scenarios
//                followed by randomized scans against a cell-array reference.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_scan_receiver;

    localparam int MAX_GAP = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [1:0]  row, col, xoro;
    logic [17:0] board;
    logic        frame_valid, changed, locked, seq_err;
    logic [3:0]  x_count, o_count;

    int checks = 0;
    int errors = 0;

    // Reference: frame progress as "next cell wanted" (-1 while hunting).
    int         m_next;
    int         m_gap;
    int         m_cells [9];
    int         m_board [9];
    bit         m_locked, e_fv, e_ch, e_se;

    board_scan_receiver #(.MAX_GAP(MAX_GAP), .GAP_W(3)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid),
        .row(row), .col(col), .xoro(xoro),
        .board(board), .frame_valid(frame_valid), .changed(changed),
        .x_count(x_count), .o_count(o_count), .locked(locked), .seq_err(seq_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [17:0] m_image();
        logic [17:0] p;
        p = '0;
        for (int k = 0; k < 9; k++) p[2*k +: 2] = 2'(m_board[k]);
        return p;
    endfunction

    function automatic int m_count(input int code);
        int n;
        n = 0;
        for (int k = 0; k < 9; k++) if (m_board[k] == code) n++;
        return n;
    endfunction

    // Advance the reference by one clock with the given inputs.
    task automatic model_step(input bit rn, input bit v, input int r, input int c, input int x);
        bit good;
        int idx;
        bit diff;
        e_fv = 0; e_ch = 0; e_se = 0;
        if (!rn) begin
            m_next = -1; m_gap = 0; m_locked = 0;
            for (int k = 0; k < 9; k++) m_board[k] = 0;
            return;
        end
        good = v && r < 3 && c < 3 && x != 3;
        idx  = r * 3 + c;
        if (m_next < 0) begin
            if (good && idx == 0) begin
                m_cells[0] = x; m_next = 1; m_gap = 0;
            end
        end else if (v) begin
            if (good && idx == m_next) begin
                m_cells[idx] = x; m_gap = 0;
                if (idx == 8) begin
                    diff = 0;
                    for (int k = 0; k < 9; k++) begin
                        if (m_board[k] != m_cells[k]) diff = 1;
                        m_board[k] = m_cells[k];
                    end
                    e_fv = 1; e_ch = diff; m_locked = 1; m_next = -1;
                end else begin
                    m_next++;
                end
            end else begin
                e_se = 1; m_locked = 0; m_gap = 0;
                if (good && idx == 0) begin
                    m_cells[0] = x; m_next = 1;
                end else begin
                    m_next = -1;
                end
            end
        end else begin
            m_gap++;
            if (m_gap > MAX_GAP) begin
                e_se = 1; m_locked = 0; m_next = -1; m_gap = 0;
            end
        end
    endtask

    // One clock: drive on the falling edge, compare just after the rising edge.
    task automatic cycle(input bit rn, input bit v, input int r, input int c, input int x);
        @(negedge clk);
        reset = rn; in_valid = v; row = 2'(r); col = 2'(c); xoro = 2'(x);
        model_step(rn, v, r, c, x);
        @(posedge clk);
        #1;
        check("board",       32'(board),       32'(m_image()));
        check("frame_valid", 32'(frame_valid), 32'(e_fv));
        check("changed",     32'(changed),     32'(e_ch));
        check("seq_err",     32'(seq_err),     32'(e_se));
        check("locked",      32'(locked),      32'(m_locked));
        check("x_count",     32'(x_count),     32'(m_count(1)));
        check("o_count",     32'(o_count),     32'(m_count(2)));
    endtask

    task automatic beats(input logic [17:0] img, input int from, input int to);
        logic [17:0] t;
        t = img;
        for (int k = from; k <= to; k++) cycle(1, 1, k / 3, k % 3, int'(t[2*k +: 2]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1, 0, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
    endtask

    function automatic logic [17:0] rand_img();
        logic [17:0] p;
        for (int k = 0; k < 9; k++) p[2*k +: 2] = 2'($urandom_range(0, 2));
        return p;
    endfunction

    initial begin
        logic [17:0] img;
        m_next = -1; m_gap = 0; m_locked = 0;
        for (int k = 0; k < 9; k++) begin m_cells[k] = 0; m_board[k] = 0; end
        reset = 1'b0; in_valid = 1'b0; row = '0; col = '0; xoro = '0;

        // Reset, then an all-empty frame: commits with no change.
        cycle(0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0);
        check("reset_locked", 32'(locked), 32'd0);
        beats(18'd0, 0, 8);
        check("empty_fv", 32'(frame_valid), 32'd1);
        check("empty_changed", 32'(changed), 32'd0);

        // X at (1,1), O at (0,2), sent twice back to back.
        beats(18'h00120, 0, 8);
        check("xo_board", 32'(board), 32'h120);
        check("xo_changed", 32'(changed), 32'd1);
        check("xo_xcount", 32'(x_count), 32'd1);
        check("xo_ocount", 32'(o_count), 32'd1);
        beats(18'h00120, 0, 8);
        check("xo_repeat_changed", 32'(changed), 32'd0);

        // Skipped cell (1,2), then recovery.
        img = rand_img();
        beats(img, 0, 4);
        beats(img, 6, 6);
        check("skip_seq_err", 32'(seq_err), 32'd1);
        check("skip_board", 32'(board), 32'h120);
        beats(rand_img(), 0, 8);

        // Illegal contents mid-frame, then a mid-scan restart.
        cycle(1, 1, 0, 0, 1);
        cycle(1, 1, 0, 1, 2);
        cycle(1, 1, 0, 2, 3);
        check("illegal_seq_err", 32'(seq_err), 32'd1);
        img = rand_img();
        beats(img, 0, 3);
        beats(rand_img(), 0, 8);

        // Gap tolerance: MAX_GAP idles survive, one more aborts.
        img = rand_img();
        beats(img, 0, 3); idle(MAX_GAP); beats(img, 4, 8);
        check("gap_ok_fv", 32'(frame_valid), 32'd1);
        img = rand_img();
        beats(img, 0, 3); idle(MAX_GAP + 1);
        check("gap_bad_seq_err", 32'(seq_err), 32'd1);
        beats(img, 4, 8);

        // Reset lands on the last beat of a frame.
        img = rand_img();
        beats(img, 0, 7);
        cycle(0, 1, 2, 2, 1);
        check("rst_last_board", 32'(board), 32'd0);
        beats(rand_img(), 0, 8);

        // Randomized scans with occasional faults.
        for (int it = 0; it < 300; it++) begin
            img = rand_img();
            for (int k = 0; k < 9; k++) begin
                int dice;
                dice = $urandom_range(0, 99);
                if (dice < 85) begin
                    cycle(1, 1, k / 3, k % 3, ($urandom_range(0, 49) == 0) ? 3 : int'(img[2*k +: 2]));
                end else if (dice < 93) begin
                    idle($urandom_range(1, 6));
                    cycle(1, 1, k / 3, k % 3, int'(img[2*k +: 2]));
                end else if (dice < 98) begin
                    cycle(1, 1, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
                end else begin
                    cycle(0, $urandom_range(0, 1), k / 3, k % 3, 0);
                end
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/board_scan_receiver.md
Name: board_scan_receiver

Overview:
Receiver for the board-scan output stream produced by the chip's output controller. That controller emits one cell per cycle as (row, col, xoro) in raster order (0,0),(0,1),…,(2,2) and then wraps. This block sits on the display/host side. It locks onto the scan, rebuilds the 18-bit board image, validates it, and publishes a coherent snapshot once per complete frame.

Parameters:
MAX_GAP, 4, maximum consecutive idle cycles (in_valid low) tolerated inside a frame before it is aborted.
GAP_W, 3, width of the gap counter; must hold MAX_GAP.

Ports:
clk  input  1  single system clock, rising edge.
reset  input  1  synchronous, active-low reset.
in_valid  input  1  high when row/col/xoro carry a scan beat this cycle.
row  input  2  scanned row, 0..2.
col  input  2  scanned column, 0..2.
xoro  input  2  cell contents: 00 empty, 01 X, 10 O, 11 illegal.
board  output  18  committed board; cell k=row*3+col occupies bits [2k+1:2k].
frame_valid  output  1  one-cycle pulse when board is updated.
changed  output  1  one-cycle pulse with frame_valid when the new board differs from the previous one.
x_count  output  4  number of X cells in board.
o_count  output  4  number of O cells in board.
locked  output  1  high after the first good frame; low after any error until the next good frame.
seq_err  output  1  one-cycle pulse on any protocol error.

Behaviour:
- Reset: when reset=0 at a rising clk edge, all outputs go to 0, the shadow image clears, the state becomes HUNT, and the expected index and gap counter go to 0. Reset takes priority over all other events, including a frame in progress.
- Beat index: idx = row*3+col. A beat is bad if row==3, col==3, or xoro==11.
- State HUNT:
  - Ignores every beat except a good beat with idx==0.
  - On that beat: writes shadow cell 0, sets exp=1, clears the gap counter, and moves to COLLECT.
  - Bad beats in HUNT do not raise seq_err.
- State COLLECT, valid beat:
  - Good beat with idx==exp: write shadow cell exp and clear the gap counter.
    - If exp<8: exp increments.
    - If exp==8: commit (see below) and return to HUNT with exp=0.
  - Otherwise: pulse seq_err, clear locked, and discard the shadow. If the offending beat is a good beat with idx==0, restart immediately (shadow cell 0 written, exp=1, stay in COLLECT). Else go to HUNT.
- State COLLECT, idle cycle (in_valid=0): the gap counter increments. When it would exceed MAX_GAP: pulse seq_err, clear locked, and go to HUNT.
- Commit happens on the cycle after the idx==8 beat is sampled (one-cycle latency from the last beat to frame_valid):
  - board <= shadow including cell 8.
  - frame_valid=1.
  - changed=1 iff the new board != the old board. The first frame after reset compares against all-zero.
  - x_count and o_count are recomputed from the new board and update in the same cycle as board.
  - locked=1.
- Back-to-back frames: a good idx 0 beat on the cycle right after the idx 8 beat is accepted. No dead cycle is required.
- board, x_count and o_count hold between commits. A partial frame never alters them.
- seq_err, frame_valid and changed are never high for more than one consecutive cycle per event. seq_err and frame_valid are never high in the same cycle.
- No validation of game legality: counts are reported, not checked.

Test Plan:
- Reset low for 2 cycles, then 9 continuous good beats in raster order, all xoro=00 -> frame_valid pulses 1 cycle after the 9th beat; board=0, changed=1 is NOT required (equal to reset value, so changed=0); locked=1.
- Continuous scan with cell (1,1)=01 and (0,2)=10, repeated twice -> first frame: board=18'h00120, x_count=1, o_count=1, changed=1. Second frame: same board, changed=0.
- Frame with beat (1,2) skipped (goes (1,1)->(2,0)) -> seq_err pulse on the (2,0) beat; locked=0; board unchanged; the next complete frame recovers with locked=1.
- Beat (0,2) with xoro=11 mid-frame -> seq_err pulse, HUNT. Next: (0,0) mid-scan arrival during COLLECT -> immediate restart, and the subsequent full frame commits normally.
- MAX_GAP=4: in_valid low for 4 cycles mid-frame then resume -> frame commits. Low for 5 cycles -> seq_err on the 5th idle cycle, no commit.
- reset asserted on the cycle of the idx-8 beat -> no frame_valid, board=0, state HUNT. The next full frame after release commits.
